// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the 6-way memory-port round-robin arbiter.
package mem_arb_pkg;

    localparam int ARB_NREQ  = 6;
    localparam int ARB_IDX_W = 3;

    typedef logic [ARB_NREQ-1:0]  arb_vec_t;
    typedef logic [ARB_IDX_W-1:0] arb_idx_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    // Advance a requester index by one, wrapping 5 -> 0.
    function automatic arb_idx_t arb_next_idx(input arb_idx_t idx);
        return (idx >= arb_idx_t'(ARB_NREQ - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick6.sv
// Combinational round-robin pick: first set request bit scanning from ptr
// upward with wrap 5 -> 0. The result is one-hot or zero.
module rr_pick6
    import mem_arb_pkg::*;
(
    input  arb_vec_t req,
    input  arb_idx_t ptr,
    output arb_vec_t pick,
    output arb_idx_t pick_idx,
    output logic     any
);

    // Walk the six positions starting at the pointer and keep the first hit.
    always_comb begin
        arb_idx_t cur;
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        cur      = (ptr > arb_idx_t'(ARB_NREQ - 1)) ? '0 : ptr;
        for (int i = 0; i < ARB_NREQ; i++) begin
            if (!any && req[cur]) begin
                pick[cur] = 1'b1;
                pick_idx  = cur;
                any       = 1'b1;
            end
            cur = arb_next_idx(cur);
        end
    end

endmodule

// File: rtl/mem_port_arb6.sv
// Round-robin arbiter for the shared memory-system port (6 requesters).
// Grants are registered and held until the owner signals done or drops its
// request; a release re-picks in the same cycle so grants go back-to-back.
// Optional watchdog release is enabled by defining MEM_ARB_WATCHDOG_EN.
module mem_port_arb6
    import mem_arb_pkg::*;
#(
    parameter int NREQ     = 6,
    parameter int HOLD_MAX = 255,
    parameter int WDT_W    = 8
) (
    input  logic       cpu_clock_i,
    input  logic       cpu_reset_i,
    input  logic       flush_i,
    input  logic [5:0] req_i,
    input  logic       done_i,
    output logic [5:0] grant_o,
    output logic       grant_valid_o,
    output logic [2:0] grant_idx_o,
    output logic       timeout_o
);

    if (NREQ != ARB_NREQ) begin : g_bad_nreq
        $error("mem_port_arb6 supports only NREQ == 6");
    end

    if (HOLD_MAX < 1 || HOLD_MAX >= (1 << WDT_W)) begin : g_bad_hold
        $error("mem_port_arb6 requires 1 <= HOLD_MAX < 2**WDT_W");
    end

    arb_state_t state_q, state_d;
    arb_vec_t   grant_q, grant_d;
    arb_idx_t   grant_idx_q, grant_idx_d;
    arb_idx_t   rr_ptr_q, rr_ptr_d;

    arb_idx_t   pick_ptr;
    arb_vec_t   pick;
    arb_idx_t   pick_idx;
    logic       pick_any;
    logic       owner_release;
    logic       wdt_expire;
    logic       release_evt;

`ifdef MEM_ARB_WATCHDOG_EN
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             timeout_q, timeout_d;

    assign wdt_expire = (state_q == ARB_GRANT) && (wdt_q == WDT_W'(HOLD_MAX - 1));
    assign timeout_o  = timeout_q;
`else
    assign wdt_expire = 1'b0;
    assign timeout_o  = 1'b0;
`endif

    // On a release the pick already uses the advanced pointer, which makes the
    // just-released owner the lowest priority for the back-to-back grant.
    assign owner_release = (state_q == ARB_GRANT) && (done_i || !req_i[grant_idx_q]);
    assign release_evt   = owner_release || wdt_expire;
    assign pick_ptr      = (state_q == ARB_GRANT) ? arb_next_idx(grant_idx_q) : rr_ptr_q;

    rr_pick6 u_pick (
        .req      (req_i),
        .ptr      (pick_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    // Next-state logic: flush overrides everything, IDLE grants on any request,
    // GRANT holds until a release and then re-picks or falls back to IDLE.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef MEM_ARB_WATCHDOG_EN
        wdt_d       = wdt_q;
        timeout_d   = 1'b0;
`endif
        if (flush_i) begin
            state_d     = ARB_IDLE;
            grant_d     = '0;
            grant_idx_d = '0;
`ifdef MEM_ARB_WATCHDOG_EN
            wdt_d       = '0;
`endif
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        state_d     = ARB_GRANT;
                        grant_d     = pick;
                        grant_idx_d = pick_idx;
`ifdef MEM_ARB_WATCHDOG_EN
                        wdt_d       = '0;
`endif
                    end
                end
                ARB_GRANT: begin
                    if (release_evt) begin
                        rr_ptr_d = pick_ptr;
`ifdef MEM_ARB_WATCHDOG_EN
                        timeout_d = wdt_expire && !owner_release;
                        wdt_d     = '0;
`endif
                        if (pick_any) begin
                            grant_d     = pick;
                            grant_idx_d = pick_idx;
                        end else begin
                            state_d     = ARB_IDLE;
                            grant_d     = '0;
                            grant_idx_d = '0;
                        end
                    end else begin
`ifdef MEM_ARB_WATCHDOG_EN
                        wdt_d = wdt_q + 1'b1;
`endif
                    end
                end
                default: begin
                    state_d     = ARB_IDLE;
                    grant_d     = '0;
                    grant_idx_d = '0;
                end
            endcase
        end
    end

    // All arbiter state, including the visible grant outputs, lives in these flops.
    always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
        if (cpu_reset_i) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
`ifdef MEM_ARB_WATCHDOG_EN
            wdt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef MEM_ARB_WATCHDOG_EN
            wdt_q       <= wdt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = |grant_q;
    assign grant_idx_o   = grant_idx_q;

endmodule

// File: tb/tb_mem_port_arb6.sv
// Self-checking bench for mem_port_arb6: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural round-robin model. Honors MEM_ARB_WATCHDOG_EN.
module tb_mem_port_arb6;

`ifdef MEM_ARB_WATCHDOG_EN
    localparam int TB_HOLD = 4;
`else
    localparam int TB_HOLD = 255;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [5:0] req;
    logic       done;
    logic [5:0] grant_o;
    logic       grant_valid_o;
    logic [2:0] grant_idx_o;
    logic       timeout_o;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: owner index (-1 when idle), pointer, cycles held, timeout pulse.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_tout  = 1'b0;
    bit m_let_go;
    bit m_due;

    mem_port_arb6 #(
        .NREQ     (6),
        .HOLD_MAX (TB_HOLD),
        .WDT_W    (8)
    ) dut (
        .cpu_clock_i   (clk),
        .cpu_reset_i   (rst),
        .flush_i       (flush),
        .req_i         (req),
        .done_i        (done),
        .grant_o       (grant_o),
        .grant_valid_o (grant_valid_o),
        .grant_idx_o   (grant_idx_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk = ~clk;

    // First requesting index found scanning p, p+1, ... modulo 6; -1 if none.
    function automatic int rr_pick(input logic [5:0] r, input int p);
        for (int k = 0; k < 6; k++) begin
            if (r[(p + k) % 6]) return (p + k) % 6;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [5:0] exp_grant,
                               input logic [2:0] exp_idx, input logic exp_valid,
                               input logic exp_tout);
        vectors++;
        if (grant_o !== exp_grant || grant_idx_o !== exp_idx ||
            grant_valid_o !== exp_valid || timeout_o !== exp_tout) begin
            miscompares++;
            $display("[TB] FAIL %s: got grant=%b idx=%0d valid=%b timeout=%b, want grant=%b idx=%0d valid=%b timeout=%b",
                     name, grant_o, grant_idx_o, grant_valid_o, timeout_o,
                     exp_grant, exp_idx, exp_valid, exp_tout);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] r, input logic d, input logic f);
        req   = r;
        done  = d;
        flush = f;
        @(posedge clk);
        #2;
    endtask

    task automatic checkIdx(input string name, input int idx, input logic tout);
        logic [5:0] eg;
        eg = 6'b000001 << idx;
        checkOutput(name, eg, 3'(idx), 1'b1, tout);
    endtask

    // Behavioural model advanced on every active edge from the applied inputs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            m_tout  = 1'b0;
        end else if (flush) begin
            m_owner = -1;
            m_hold  = 0;
            m_tout  = 1'b0;
        end else if (m_owner < 0) begin
            m_tout  = 1'b0;
            m_owner = rr_pick(req, m_ptr);
            m_hold  = 0;
        end else begin
            m_let_go = done || !req[m_owner];
`ifdef MEM_ARB_WATCHDOG_EN
            m_due = (m_hold + 1 >= TB_HOLD);
`else
            m_due = 1'b0;
`endif
            m_tout = m_due && !m_let_go;
            if (m_let_go || m_due) begin
                m_ptr   = (m_owner + 1) % 6;
                m_owner = rr_pick(req, m_ptr);
                m_hold  = 0;
            end else begin
                m_hold++;
            end
        end
    end

    // Every cycle: outputs must match the model and satisfy the one-hot invariants.
    always @(negedge clk) begin
        logic [5:0] eg;
        eg = (m_owner < 0) ? 6'b0 : (6'b000001 << m_owner);
        checkOutput("model", eg, (m_owner < 0) ? 3'd0 : 3'(m_owner), m_owner >= 0, m_tout);
        vectors++;
        if (!$onehot0(grant_o) || grant_valid_o !== (|grant_o) ||
            (grant_valid_o && grant_o !== (6'b000001 << grant_idx_o))) begin
            miscompares++;
            $display("[TB] FAIL invariant: got grant=%b idx=%0d valid=%b", grant_o, grant_idx_o, grant_valid_o);
        end
    end

    initial begin
        logic [5:0] r;
        rst   = 1'b1;
        req   = '0;
        done  = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_state", 6'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Single request, then done with the request dropped returns to idle.
        applyStimulus(6'b000100, 1'b0, 1'b0);
        checkOutput("first_grant", 6'b000100, 3'd2, 1'b1, 1'b0);
        applyStimulus(6'b000000, 1'b1, 1'b0);
        checkOutput("done_to_idle", 6'b0, 3'd0, 1'b0, 1'b0);

        // Fresh pointer, all requesting: 0,1,2,3,4,5,0 back-to-back.
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        applyStimulus(6'b111111, 1'b0, 1'b0);
        checkIdx("rr_start", 0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(6'b111111, 1'b1, 1'b0);
            checkIdx("rr_seq", i % 6, 1'b0);
        end

        // Wrap from 4 to 0 rather than regranting 4.
        applyStimulus(6'b010000, 1'b1, 1'b0);
        checkIdx("to_4", 4, 1'b0);
        applyStimulus(6'b010001, 1'b1, 1'b0);
        checkIdx("wrap_to_0", 0, 1'b0);

        // Abandonment by requester 1 acts as a release.
        applyStimulus(6'b000010, 1'b1, 1'b0);
        checkIdx("to_1", 1, 1'b0);
        applyStimulus(6'b001000, 1'b0, 1'b0);
        checkIdx("abandon_to_3", 3, 1'b0);

        // Reach owner 3 with pointer 3, flush, then pointer must be retained.
        applyStimulus(6'b000100, 1'b1, 1'b0);
        checkIdx("to_2", 2, 1'b0);
        applyStimulus(6'b001000, 1'b1, 1'b0);
        checkIdx("to_3", 3, 1'b0);
        applyStimulus(6'b001000, 1'b0, 1'b1);
        checkOutput("flush", 6'b0, 3'd0, 1'b0, 1'b0);
        applyStimulus(6'b111111, 1'b0, 1'b0);
        checkIdx("ptr_retained", 3, 1'b0);

        // Asynchronous reset while a grant is held.
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 6'b0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;

`ifdef MEM_ARB_WATCHDOG_EN
        applyStimulus(6'b000011, 1'b0, 1'b0);
        checkIdx("wdt_grant", 0, 1'b0);
        repeat (3) begin
            applyStimulus(6'b000011, 1'b0, 1'b0);
            checkIdx("wdt_hold", 0, 1'b0);
        end
        applyStimulus(6'b000011, 1'b0, 1'b0);
        checkIdx("wdt_release", 1, 1'b1);
        applyStimulus(6'b000011, 1'b0, 1'b0);
        checkIdx("wdt_pulse_end", 1, 1'b0);
`else
        applyStimulus(6'b000001, 1'b0, 1'b0);
        checkIdx("hold_grant", 0, 1'b0);
        repeat (1000) applyStimulus(6'b000001, 1'b0, 1'b0);
        checkIdx("hold_1000", 0, 1'b0);
`endif
        applyStimulus(6'b000000, 1'b1, 1'b0);

        // Randomized traffic with sticky requests, random done and rare flushes.
        r = '0;
        repeat (3000) begin
            for (int b = 0; b < 6; b++) begin
                if (r[b]) r[b] = ($urandom_range(0, 7) != 0);
                else      r[b] = ($urandom_range(0, 3) == 0);
            end
            applyStimulus(r, $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arb6.md
Name: mem_port_arb6

Overview:
- 6-requester round-robin arbiter for the shared memory-system port (load/store queues, fetch, prefetch, page walker, writeback).
- Produces a registered one-hot grant vector plus its binary index, and holds the grant until the owner signals completion.
- Its grant_o is the vector the memory system's one-hot checkers consume, so at most one bit may ever be set.

Parameters:
- NREQ, 6, number of requesters; the design is fixed at 6, and any other value is rejected at elaboration.
- HOLD_MAX, 255, maximum grant-hold cycles before watchdog release; used only with the optional feature.
- WDT_W, 8, watchdog counter width; requires HOLD_MAX < 2**WDT_W.

Ports:
- cpu_clock_i  in  1  clock.
- cpu_reset_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous pipeline flush; drops any grant.
- req_i  in  6  request per requester; must stay high until done_i.
- done_i  in  1  owner's transaction complete, qualified by grant_valid_o.
- grant_o  out  6  registered one-hot grant; all zero when idle.
- grant_valid_o  out  1  equals OR of grant_o.
- grant_idx_o  out  3  binary index of the granted requester; 0 when idle.
- timeout_o  out  1  one-cycle pulse on watchdog release; tied 0 without the feature.

Behaviour:
- Reset values: grant_o=0, grant_valid_o=0, grant_idx_o=0, timeout_o=0, rr_ptr=0, state=IDLE.
- Two states, IDLE and GRANT.
- Pick function:
  - Take the first set bit of req_i scanning rr_ptr, rr_ptr+1, ... mod 6.
  - Index wrap is 5 -> 0.
  - The result is one-hot or zero by construction.
- IDLE:
  - If req_i != 0, register the pick into grant_o/grant_idx_o and go to GRANT.
  - Latency is 1 cycle from req rising to grant visible.
  - If req_i == 0, stay in IDLE.
- GRANT:
  - grant_o is held constant while done_i=0 and req_i[grant_idx_o]=1.
- Release event: done_i=1, or abandonment (req_i[grant_idx_o]=0). On release:
  - rr_ptr <= grant_idx_o+1 mod 6.
  - The next grant is picked in the same cycle using the new pointer and the current req_i.
  - If the pick is nonzero, grant the new requester back-to-back (no bubble) and stay in GRANT.
  - If the pick is zero, clear grant_o and go to IDLE.
  - The just-released requester has the lowest priority in that pick.
- done_i while in IDLE is ignored.
- flush_i:
  - Highest priority after reset.
  - Next cycle grant_o=0, state=IDLE, rr_ptr unchanged, no pick that cycle.
- Reset asserted mid-grant: all state returns to reset values immediately (asynchronous).
- Invariants for verification:
  - $onehot0(grant_o) always holds.
  - grant_valid_o == |grant_o.
  - grant_o == 1<<grant_idx_o whenever grant_valid_o=1.
  - Every persistently requesting port is granted within 5 grants.

Optional Feature:
- Macro: MEM_ARB_WATCHDOG_EN.
- With the macro defined:
  - A WDT_W-bit counter clears on every new grant and increments each GRANT cycle.
  - When it reaches HOLD_MAX with no release, treat it as a release event (pointer advance, same-cycle re-pick) and pulse timeout_o for 1 cycle.
  - The counter resets to 0 on reset and on flush.
- Without the macro: no counter, timeout_o constant 0, grant held indefinitely.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_GRANT}.
  - Constants ARB_NREQ=6 and ARB_IDX_W=3.
  - Typedef arb_vec_t (logic [5:0]).
- Sub-module rr_pick6:
  - Purely combinational.
  - Inputs: req (6), ptr (3).
  - Outputs: onehot pick (6), pick_idx (3), any.
  - Instantiated once and shared by the IDLE and release paths.

Test Plan:
- Reset then req_i=6'b000100 -> next cycle grant_o=6'b000100, grant_idx_o=2, grant_valid_o=1; done_i -> grant_o=0 next cycle, rr_ptr=3.
- req_i=6'b111111 held, done_i pulsed each grant -> grant_idx_o sequence 0,1,2,3,4,5,0 with no idle cycles between grants.
- Granted to 4 with req_i=6'b010001, done_i -> grant moves to 0 (wrap), not back to 4.
- Granted to 1, req_i[1] drops with done_i=0 -> treated as release; with req_i=6'b001000 -> grant_o=6'b001000 the next cycle.
- flush_i during GRANT on idx 3 -> next cycle grant_o=0, IDLE; req_i=6'b111111 -> grant idx 3 (pointer retained); async reset mid-grant -> all outputs 0 immediately.
- MEM_ARB_WATCHDOG_EN, HOLD_MAX=4, grant to 0 with no done_i:
  - timeout_o pulses after 4 grant cycles.
  - With req_i=6'b000011, grant moves to 1.
  - Without the macro, grant holds for 1000 cycles.
